pattern_player: RTL and testbench

// Programmable stimulus source: a small table of (value, hold) entries, written through a config port, is played
//   out as a timed sequence of WIDTH-bit words on d, one entry after another.

---
 rtl/pattern_player.sv | 154 +++++++++++++++
 tb/tb_pattern_player.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_player.sv
// Table-driven stimulus source: plays (value, hold) entries written through a config
// port as a timed word sequence on d, with one-shot, looped and abort control.
module pattern_player #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    input  logic              loop,
    input  logic              abort,
    output logic [WIDTH-1:0]  d,
    output logic              valid,
    output logic [ADDR_W-1:0] idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_n;
    logic [WIDTH-1:0]  d_q, d_n;
    logic              valid_q, valid_n;
    logic [ADDR_W-1:0] idx_q, idx_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [HOLD_W-1:0] cnt_q, cnt_n;
    logic [ADDR_W:0]   len_q, len_n;

    logic [WIDTH-1:0]  val_mem  [DEPTH];
    logic [HOLD_W-1:0] hold_mem [DEPTH];

    logic [ADDR_W-1:0] next_idx;
    logic              last;

    // A hold of 0 behaves as 1, so the countdown starts at max(h,1)-1.
    function automatic logic [HOLD_W-1:0] hold_init(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : h - 1'b1;
    endfunction

    function automatic logic [ADDR_W:0] len_clamp(input logic [ADDR_W:0] l);
        return (l > DEPTH_L) ? DEPTH_L : l;
    endfunction

    assign next_idx = idx_q + 1'b1;
    assign last     = ({1'b0, idx_q} == (len_q - 1'b1));

    // Table writes are only honoured while idle; writes during playback are dropped.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && cfg_we) begin
            val_mem[cfg_addr]  <= cfg_data;
            hold_mem[cfg_addr] <= cfg_hold;
        end
    end

    always_comb begin
        state_n = state_q;
        d_n     = d_q;
        valid_n = valid_q;
        idx_n   = idx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        cnt_n   = cnt_q;
        len_n   = len_q;
        case (state_q)
            IDLE: begin
                if (!abort && !cfg_we && start) begin
                    if (len != '0) begin
                        state_n = PLAY;
                        len_n   = len_clamp(len);
                        idx_n   = '0;
                        d_n     = val_mem[0];
                        cnt_n   = hold_init(hold_mem[0]);
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (abort) begin
                    state_n = IDLE;
                    d_n     = '0;
                    valid_n = 1'b0;
                    idx_n   = '0;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                end else if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (last) begin
                    if (loop) begin
                        idx_n = '0;
                        d_n   = val_mem[0];
                        cnt_n = hold_init(hold_mem[0]);
                    end else begin
                        state_n = IDLE;
                        d_n     = '0;
                        valid_n = 1'b0;
                        idx_n   = '0;
                        busy_n  = 1'b0;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end
                end else begin
                    idx_n = next_idx;
                    d_n   = val_mem[next_idx];
                    cnt_n = hold_init(hold_mem[next_idx]);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_n;
            d_q     <= d_n;
            valid_q <= valid_n;
            idx_q   <= idx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            cnt_q   <= cnt_n;
            len_q   <= len_n;
        end
    end

    assign d     = d_q;
    assign valid = valid_q;
    assign idx   = idx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player: a cycle-by-cycle vector table plus hand-written
// sequences for loop period and maximum hold.
module tb_pattern_player;

    logic       clk = 1'b0;
    logic       rst, cfg_we, start, loop, abort;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_data, cfg_hold;
    logic [3:0] len;
    logic [3:0] d;
    logic       valid, busy, done;
    logic [2:0] idx;

    int n_chk  = 0;
    int n_fail = 0;

    pattern_player #(.WIDTH(4), .DEPTH(8), .ADDR_W(3), .HOLD_W(4)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_hold(cfg_hold), .len(len), .start(start), .loop(loop), .abort(abort),
        .d(d), .valid(valid), .idx(idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [2:0] addr;
        logic [3:0] data;
        logic [3:0] hold;
        logic [3:0] len;
        logic       start;
        logic       lp;
        logic       ab;
        logic [3:0] ed;
        logic       ev;
        logic [2:0] ei;
        logic       eb;
        logic       edn;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, we, input logic [2:0] a, input logic [3:0] dv, h, l,
                       input logic st, lp, ab, input logic [3:0] ed, input logic ev,
                       input logic [2:0] ei, input logic eb, edn, input string tag);
        vec_t v;
        v.rst = r; v.we = we; v.addr = a; v.data = dv; v.hold = h; v.len = l;
        v.start = st; v.lp = lp; v.ab = ab;
        v.ed = ed; v.ev = ev; v.ei = ei; v.eb = eb; v.edn = edn; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic w(input logic [2:0] a, input logic [3:0] dv, h);
        add(0, 1, a, dv, h, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle write");
    endtask

    task automatic s(input logic [3:0] l, input logic lp, input logic [3:0] ed, input logic ev,
                     input logic [2:0] ei, input logic eb, edn, input string tag);
        add(0, 0, 0, 0, 0, l, 1, lp, 0, ed, ev, ei, eb, edn, tag);
    endtask

    task automatic e(input logic lp, input logic [3:0] ed, input logic [2:0] ei, input string tag);
        add(0, 0, 0, 0, 0, 0, 0, lp, 0, ed, 1, ei, 1, 0, tag);
    endtask

    task automatic z(input logic lp, ab, edn, input string tag);
        add(0, 0, 0, 0, 0, 0, 0, lp, ab, 0, 0, 0, 0, edn, tag);
    endtask

    // Remainder of the 4-entry sequence after the first word: 3,7,7,7,E,E,E,A,A
    task automatic body4(input logic lp);
        e(lp, 4'h3, 0, "entry0 hold");
        for (int i = 0; i < 3; i++) e(lp, 4'h7, 1, "entry1");
        for (int i = 0; i < 3; i++) e(lp, 4'hE, 2, "entry2");
        for (int i = 0; i < 2; i++) e(lp, 4'hA, 3, "entry3");
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        logic [9:0] got, exp;
        rst = v.rst; cfg_we = v.we; cfg_addr = v.addr; cfg_data = v.data; cfg_hold = v.hold;
        len = v.len; start = v.start; loop = v.lp; abort = v.ab;
        tick();
        got = {d, valid, idx, busy, done};
        exp = {v.ed, v.ev, v.ei, v.eb, v.edn};
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: {d,valid,idx,busy,done} got %h/%b/%0d/%b/%b expected %h/%b/%0d/%b/%b",
                     n, v.tag, got[9:6], got[5], got[4:2], got[1], got[0],
                     exp[9:6], exp[5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        int         n;
        logic [2:0] prev;

        rst = 1; cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_hold = 0;
        len = 0; start = 0; loop = 0; abort = 0;

        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        w(0, 4'h3, 2); w(1, 4'h7, 3); w(2, 4'hE, 3); w(3, 4'hA, 2);
        w(4, 4'h5, 0); w(5, 4'h1, 2); w(6, 4'h2, 0); w(7, 4'hF, 1);

        s(4, 0, 4'h3, 1, 0, 1, 0, "one-shot start");
        body4(0);
        z(0, 0, 1, "one-shot done");
        z(0, 0, 0, "done one cycle");

        s(4, 1, 4'h3, 1, 0, 1, 0, "loop start");
        body4(1);
        e(1, 4'h3, 0, "loop wrap");
        e(1, 4'h3, 0, "loop entry0 hold");
        e(1, 4'h7, 1, "loop entry1 first");
        e(1, 4'h7, 1, "loop entry1 second");
        z(1, 1, 0, "abort in entry1");
        z(0, 0, 0, "idle after abort");

        s(4, 0, 4'h3, 1, 0, 1, 0, "replay after abort");
        body4(0);
        z(0, 1, 0, "abort beats end");
        z(0, 0, 0, "no done after abort");

        s(0, 0, 4'h0, 0, 0, 0, 1, "len0 done");
        z(0, 0, 0, "len0 done ends");
        add(0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0, 0, "abort over start");
        add(0, 1, 0, 4'h3, 2, 4, 1, 0, 0, 0, 0, 0, 0, 0, "write over start");

        s(15, 0, 4'h3, 1, 0, 1, 0, "len15 start");
        e(0, 4'h3, 0, "len15 e0");
        for (int i = 0; i < 3; i++) e(0, 4'h7, 1, "len15 e1");
        e(0, 4'hE, 2, "len15 e2");
        e(0, 4'hE, 2, "len15 e2");
        add(0, 1, 0, 4'h9, 1, 0, 0, 0, 0, 4'hE, 1, 2, 1, 0, "busy write");
        e(0, 4'hA, 3, "len15 e3");
        e(0, 4'hA, 3, "len15 e3");
        e(0, 4'h5, 4, "hold0 entry");
        e(0, 4'h1, 5, "len15 e5");
        e(0, 4'h1, 5, "len15 e5");
        e(0, 4'h2, 6, "hold0 entry6");
        e(0, 4'hF, 7, "len15 e7");
        z(0, 0, 1, "len15 done");
        z(0, 0, 0, "len15 idle");

        s(1, 0, 4'h3, 1, 0, 1, 0, "entry0 unchanged");
        e(0, 4'h3, 0, "entry0 unchanged hold");
        z(0, 0, 1, "len1 done");
        z(0, 0, 0, "len1 idle");

        s(4, 0, 4'h3, 1, 0, 1, 0, "pre-reset start");
        e(0, 4'h3, 0, "pre-reset e0");
        e(0, 4'h7, 1, "pre-reset e1");
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset mid-play");
        z(0, 0, 0, "idle after reset");
        s(4, 0, 4'h3, 1, 0, 1, 0, "restart");
        body4(0);
        z(0, 0, 1, "restart done");
        z(0, 0, 0, "restart idle");

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Looped playback period: wrap from entry 3 to entry 0 every 10 cycles.
        rst = 0; cfg_we = 0; abort = 0; start = 1; len = 4; loop = 1;
        tick();
        start = 0;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            prev = idx;
            do begin
                prev = idx;
                tick();
                n++;
            end while (!(prev == 3'd3 && idx == 3'd0) && n < 50);
            chk("loop period", n, 10);
            chk("loop wrap word", {d, valid, done}, {4'h3, 1'b1, 1'b0});
        end
        abort = 1;
        tick();
        abort = 0; loop = 0;
        chk("loop abort busy", {busy, valid, done}, 3'b000);

        // Maximum hold: 15 cycles on one entry, then a single done pulse.
        cfg_we = 1; cfg_addr = 0; cfg_data = 4'h6; cfg_hold = 4'hF;
        tick();
        cfg_we = 0; start = 1; len = 1;
        tick();
        start = 0;
        n = 0;
        while (valid && d == 4'h6 && n < 40) begin
            n++;
            tick();
        end
        chk("max hold cycles", n, 15);
        chk("max hold done", {done, valid, busy}, 3'b100);
        tick();
        chk("max hold done width", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
